// File: rtl/cellrv32_package.sv
// Shared vector-unit definitions used by the reduction execution unit:
// the issue-to-execute types, the vred* funct6 encodings, the reduction
// operation enum with identity values, and the scalar combine helpers.
// Optional feature macro: CELLRV32_VRDC_MINMAX_EN builds the min/max/minu/maxu
// compare logic; without it those reductions pass vs1[0] through unchanged.
package cellrv32_package;

  localparam int XLEN_C = 32;
  localparam int VL_W_C = 8;

  localparam logic [2:0] funct3_opmvv_c = 3'b010;

  localparam logic [5:0] funct6_vredsum_c  = 6'b000000;
  localparam logic [5:0] funct6_vredand_c  = 6'b000001;
  localparam logic [5:0] funct6_vredor_c   = 6'b000010;
  localparam logic [5:0] funct6_vredxor_c  = 6'b000011;
  localparam logic [5:0] funct6_vredminu_c = 6'b000100;
  localparam logic [5:0] funct6_vredmin_c  = 6'b000101;
  localparam logic [5:0] funct6_vredmaxu_c = 6'b000110;
  localparam logic [5:0] funct6_vredmax_c  = 6'b000111;

  typedef enum logic [2:0] {
    RDC_SUM,
    RDC_AND,
    RDC_OR,
    RDC_XOR,
    RDC_MINU,
    RDC_MIN,
    RDC_MAXU,
    RDC_MAX
  } rdc_op_t;

  localparam logic [XLEN_C-1:0] rdc_id_zero_c = '0;
  localparam logic [XLEN_C-1:0] rdc_id_ones_c = '1;
  localparam logic [XLEN_C-1:0] rdc_id_smin_c = {1'b0, {(XLEN_C-1){1'b1}}};
  localparam logic [XLEN_C-1:0] rdc_id_smax_c = {1'b1, {(XLEN_C-1){1'b0}}};

  typedef struct packed {
    logic              valid;
    logic [XLEN_C-1:0] data1;
    logic [XLEN_C-1:0] data2;
  } to_vector_exec;

  typedef struct packed {
    logic [5:0]        ir_funct6;
    logic [2:0]        ir_funct3;
    logic [4:0]        dst;
    logic              head_uop;
    logic              end_uop;
    logic              is_rdc;
    logic [VL_W_C-1:0] vl;
  } to_vector_exec_info;

  // Unknown encodings fall back to sum so the sequencing never stalls.
  function automatic rdc_op_t rdc_decode(input logic [5:0] funct6, input logic [2:0] funct3);
    rdc_op_t op;
    op = RDC_SUM;
    if (funct3 == funct3_opmvv_c) begin
      case (funct6)
        funct6_vredand_c:  op = RDC_AND;
        funct6_vredor_c:   op = RDC_OR;
        funct6_vredxor_c:  op = RDC_XOR;
        funct6_vredminu_c: op = RDC_MINU;
        funct6_vredmin_c:  op = RDC_MIN;
        funct6_vredmaxu_c: op = RDC_MAXU;
        funct6_vredmax_c:  op = RDC_MAX;
        default:           op = RDC_SUM;
      endcase
    end
    return op;
  endfunction

  function automatic logic [XLEN_C-1:0] rdc_identity(input rdc_op_t op);
    logic [XLEN_C-1:0] id;
    case (op)
      RDC_AND, RDC_MINU: id = rdc_id_ones_c;
      RDC_MIN:           id = rdc_id_smin_c;
      RDC_MAX:           id = rdc_id_smax_c;
      default:           id = rdc_id_zero_c;
    endcase
    return id;
  endfunction

  // Without the compare logic the min/max family keeps operand a, so an
  // accumulator seeded with vs1[0] is carried through untouched.
  function automatic logic [XLEN_C-1:0] rdc_combine(input rdc_op_t op,
                                                    input logic [XLEN_C-1:0] a,
                                                    input logic [XLEN_C-1:0] b);
    logic [XLEN_C-1:0] r;
    case (op)
      RDC_SUM:  r = a + b;
      RDC_AND:  r = a & b;
      RDC_OR:   r = a | b;
      RDC_XOR:  r = a ^ b;
`ifdef CELLRV32_VRDC_MINMAX_EN
      RDC_MINU: r = (b < a) ? b : a;
      RDC_MIN:  r = ($signed(b) < $signed(a)) ? b : a;
      RDC_MAXU: r = (b > a) ? b : a;
      RDC_MAX:  r = ($signed(b) > $signed(a)) ? b : a;
`endif
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vector_rdc_tree.sv
// Combinational lane fold for one reduction uop. Masked lanes are replaced
// by the operation identity, then pairs are combined over log2(LANES) levels.
// Element width follows the package element width (XLEN_C).
module vector_rdc_tree
  import cellrv32_package::*;
#(
  parameter int LANES = 8
) (
  input  rdc_op_t                        op_i,
  input  logic [LANES-1:0]               valid_i,
  input  logic [LANES-1:0][XLEN_C-1:0]   data_i,
  output logic [XLEN_C-1:0]              partial_o
);

  localparam int LEVELS = $clog2(LANES);

  logic [XLEN_C-1:0] node [LANES];

  // In-place pairwise fold: level lv collapses 2*W nodes into W nodes.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      node[k] = valid_i[k] ? data_i[k] : rdc_identity(op_i);
    end
    for (int lv = 0; lv < LEVELS; lv++) begin
      for (int k = 0; k < (LANES >> (lv + 1)); k++) begin
        node[k] = rdc_combine(op_i, node[2*k], node[2*k+1]);
      end
    end
    partial_o = node[0];
  end

endmodule

// File: rtl/vector_rdc_unit.sv
// Vector reduction execution unit: folds head/middle/end reduction uops into
// one scalar accumulator and writes it to element 0 of the destination.
// Optional feature macro: CELLRV32_VRDC_MINMAX_EN (see cellrv32_package).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no reduction open; waits for a head uop, drops other uops
// S_ACCUM | reduction open; every accepted uop folds into acc
// S_WRITE | one-cycle writeback of acc (outputs already registered)
module vector_rdc_unit
  import cellrv32_package::*;
#(
  parameter int VECTOR_REGISTERS = 32,
  parameter int VECTOR_LANES     = 8,
  parameter int DATA_WIDTH       = XLEN_C
) (
  input  logic                                      clk_i,
  input  logic                                      rstn_i,
  input  logic                                      valid_i,
  input  to_vector_exec                             data_i [VECTOR_LANES],
  input  to_vector_exec_info                        info_i,
  output logic                                      ready_o,
  output logic [VECTOR_LANES-1:0]                   wr_en_o,
  output logic [$clog2(VECTOR_REGISTERS)-1:0]       wr_addr_o,
  output logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0]   wr_data_o,
  output logic [VECTOR_LANES-1:0]                   rdc_done_o
);

  localparam int AW = $clog2(VECTOR_REGISTERS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_WRITE
  } state_t;

  state_t                                 state_q;
  logic [DATA_WIDTH-1:0]                  acc_q;
  rdc_op_t                                op_q;
  logic [AW-1:0]                          dst_q;
  logic                                   ready_q;
  logic [VECTOR_LANES-1:0]                wr_en_q;
  logic [AW-1:0]                          wr_addr_q;
  logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] wr_data_q;
  logic [VECTOR_LANES-1:0]                done_q;

  logic [VECTOR_LANES-1:0]                lane_valid;
  logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] lane_data2;
  logic                                   accept;
  rdc_op_t                                head_op;
  rdc_op_t                                op_sel;
  logic [DATA_WIDTH-1:0]                  partial;
  logic [DATA_WIDTH-1:0]                  acc_src;
  logic [DATA_WIDTH-1:0]                  acc_next;
  logic [AW-1:0]                          dst_sel;
  logic                                   unused_inputs;

  // Unpack the per-lane bundle for the fold tree.
  always_comb begin
    for (int k = 0; k < VECTOR_LANES; k++) begin
      lane_valid[k] = data_i[k].valid;
      lane_data2[k] = data_i[k].data2;
    end
  end

  // vl and vs1 of the upper lanes carry no information for a reduction.
  always_comb begin
    unused_inputs = ^info_i.vl;
    for (int k = 1; k < VECTOR_LANES; k++) begin
      unused_inputs = unused_inputs ^ (^data_i[k].data1);
    end
  end

  // A head uop brings its own op/dst and seeds from vs1[0]; others reuse the latched ones.
  always_comb begin
    accept   = valid_i & ready_q & info_i.is_rdc;
    head_op  = rdc_decode(info_i.ir_funct6, info_i.ir_funct3);
    op_sel   = info_i.head_uop ? head_op : op_q;
    acc_src  = info_i.head_uop ? data_i[0].data1 : acc_q;
    acc_next = rdc_combine(op_sel, acc_src, partial);
    dst_sel  = info_i.head_uop ? AW'(info_i.dst) : dst_q;
  end

  vector_rdc_tree #(
    .LANES (VECTOR_LANES)
  ) u_tree (
    .op_i      (op_sel),
    .valid_i   (lane_valid),
    .data_i    (lane_data2),
    .partial_o (partial)
  );

  // Reduction sequencer with registered handshake and writeback outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      op_q      <= RDC_SUM;
      dst_q     <= '0;
      ready_q   <= 1'b1;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= '1;
    end else begin
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      case (state_q)
        S_IDLE, S_ACCUM: begin
          // A head in S_ACCUM restarts the reduction; a non-head in S_IDLE is dropped.
          if (accept && (info_i.head_uop || state_q == S_ACCUM)) begin
            acc_q <= acc_next;
            if (info_i.head_uop) begin
              op_q   <= head_op;
              dst_q  <= dst_sel;
              done_q <= '0;
            end
            if (info_i.end_uop) begin
              state_q      <= S_WRITE;
              ready_q      <= 1'b0;
              wr_en_q      <= VECTOR_LANES'(1);
              wr_addr_q    <= dst_sel;
              wr_data_q[0] <= acc_next;
              done_q       <= '1;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_WRITE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign rdc_done_o = done_q;

endmodule
